// File: rtl/wb_stage_pipelined_if.sv
// Writeback-stage bus: MEM-side instruction/handshake inputs plus the
// register-file write, forwarding and retire-count outputs.
interface wb_stage_pipelined_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic                      InValid;
  logic                      InReady;
  logic                      Flush;
  logic [DATA_WIDTH-1:0]     ALUOut;
  logic [DATA_WIDTH-1:0]     LinkAddr;
  logic [1:0]                ResultSel;
  logic [2:0]                LoadType;
  logic [1:0]                ByteOffset;
  logic                      RegWriteIn;
  logic [REG_ADDR_WIDTH-1:0] WriteRegAddrIn;
  logic [DATA_WIDTH-1:0]     DataOut;
  logic                      DataValid;
  logic                      RegWriteOut;
  logic [REG_ADDR_WIDTH-1:0] WriteRegAddrOut;
  logic [DATA_WIDTH-1:0]     WriteRegData;
  logic                      FwdValid;
  logic [REG_ADDR_WIDTH-1:0] FwdAddr;
  logic [DATA_WIDTH-1:0]     FwdData;
  logic [CNT_WIDTH-1:0]      RetireCount;

  // MEM stage / data memory side
  modport master (
    output InValid, Flush, ALUOut, LinkAddr, ResultSel, LoadType, ByteOffset,
           RegWriteIn, WriteRegAddrIn, DataOut, DataValid,
    input  InReady, RegWriteOut, WriteRegAddrOut, WriteRegData,
           FwdValid, FwdAddr, FwdData, RetireCount
  );

  // Writeback stage side
  modport slave (
    input  InValid, Flush, ALUOut, LinkAddr, ResultSel, LoadType, ByteOffset,
           RegWriteIn, WriteRegAddrIn, DataOut, DataValid,
    output InReady, RegWriteOut, WriteRegAddrOut, WriteRegData,
           FwdValid, FwdAddr, FwdData, RetireCount
  );
endinterface

// File: rtl/wb_stage_pipelined.sv
// Registered MIPS writeback stage: selects ALU / load / link result,
// extracts sub-word loads, waits for slow load data, issues a one-cycle
// register-file write with a matching forwarding bus, counts retirements.
module wb_stage_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int BIG_ENDIAN     = 0
) (
  input logic              Clk,
  input logic              Reset,
  wb_stage_pipelined_if.slave bus
);

  typedef enum logic {IDLE, WAIT_MEM} stateT;

  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  stateT state, stateNext;

  logic [2:0]                capLoadType;
  logic [1:0]                capByteOffset;
  logic                      capRegWrite;
  logic [REG_ADDR_WIDTH-1:0] capAddr;

  logic                      regWriteQ;
  logic [REG_ADDR_WIDTH-1:0] addrQ;
  logic [DATA_WIDTH-1:0]     dataQ;
  logic [CNT_WIDTH-1:0]      retireQ;

  logic                      accept;
  logic                      capture;
  logic                      complete;
  logic                      doneRegWrite;
  logic [REG_ADDR_WIDTH-1:0] doneAddr;
  logic [DATA_WIDTH-1:0]     doneData;

  // Sub-word load extraction from the low 32 bits of the memory word.
  function automatic logic [DATA_WIDTH-1:0] extendLoad(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [2:0]            loadType,
    input logic [1:0]            byteOffset
  );
    logic [31:0] word;
    logic [1:0]  byteIdx;
    logic        halfIdx;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    word    = raw[31:0];
    byteIdx = (BIG_ENDIAN != 0) ? ~byteOffset : byteOffset;
    halfIdx = (BIG_ENDIAN != 0) ? ~byteOffset[1] : byteOffset[1];
    case (byteIdx)
      2'd0:    byteVal = word[7:0];
      2'd1:    byteVal = word[15:8];
      2'd2:    byteVal = word[23:16];
      default: byteVal = word[31:24];
    endcase
    halfVal = halfIdx ? word[31:16] : word[15:0];
    case (loadType)
      LD_LH:   extendLoad = {{(DATA_WIDTH-16){halfVal[15]}}, halfVal};
      LD_LHU:  extendLoad = {{(DATA_WIDTH-16){1'b0}}, halfVal};
      LD_LB:   extendLoad = {{(DATA_WIDTH-8){byteVal[7]}}, byteVal};
      LD_LBU:  extendLoad = {{(DATA_WIDTH-8){1'b0}}, byteVal};
      default: extendLoad = raw;
    endcase
  endfunction

  assign bus.InReady = (state == IDLE);
  assign accept      = bus.InValid && bus.InReady && !bus.Flush;

  // State register; reset aborts any pending load.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic and selection of the result that completes this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    stateNext    = state;
    capture      = 1'b0;
    complete     = 1'b0;
    doneRegWrite = bus.RegWriteIn;
    doneAddr     = bus.WriteRegAddrIn;
    doneData     = bus.ALUOut;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.ResultSel == SEL_MEM && !bus.DataValid) begin
            capture   = 1'b1;
            stateNext = WAIT_MEM;
          end else begin
            complete = 1'b1;
            case (bus.ResultSel)
              SEL_MEM:  doneData = extendLoad(bus.DataOut, bus.LoadType, bus.ByteOffset);
              SEL_LINK: doneData = bus.LinkAddr;
              default:  doneData = bus.ALUOut;
            endcase
          end
        end
      end
      WAIT_MEM: begin
        doneRegWrite = capRegWrite;
        doneAddr     = capAddr;
        doneData     = extendLoad(bus.DataOut, capLoadType, capByteOffset);
        if (bus.Flush) begin
          stateNext = IDLE;
        end else if (bus.DataValid) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Hold the load's decode fields while waiting on memory.
  always_ff @(posedge Clk) begin
    // NOTE: these capture registers have no reset; they are only read in
    // WAIT_MEM, which is entered only on the cycle they are written.
    if (capture) begin
      capLoadType   <= bus.LoadType;
      capByteOffset <= bus.ByteOffset;
      capRegWrite   <= bus.RegWriteIn;
      capAddr       <= bus.WriteRegAddrIn;
    end
  end

  // Register the completed result, pulse the write, count retirements.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regWriteQ <= 1'b0;
      addrQ     <= '0;
      dataQ     <= '0;
      retireQ   <= '0;
    end else if (complete) begin
      regWriteQ <= doneRegWrite && (doneAddr != '0);
      addrQ     <= doneAddr;
      dataQ     <= doneData;
      retireQ   <= retireQ + CNT_ONE;
    end else begin
      regWriteQ <= 1'b0;
    end
  end

  assign bus.RegWriteOut     = regWriteQ;
  assign bus.WriteRegAddrOut = addrQ;
  assign bus.WriteRegData    = dataQ;
  assign bus.FwdValid        = regWriteQ;
  assign bus.FwdAddr         = addrQ;
  assign bus.FwdData         = dataQ;
  assign bus.RetireCount     = retireQ;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined: a 32-bit-counter instance and a
// 4-bit-counter instance driven with identical stimulus.
module tb_wb_stage_pipelined;

  logic Clk = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;
  int   expRetire = 0;

  always #5 Clk = ~Clk;

  wb_stage_pipelined_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
  wb_stage_pipelined_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  busN ();

  assign busN.InValid        = bus.InValid;
  assign busN.Flush          = bus.Flush;
  assign busN.ALUOut         = bus.ALUOut;
  assign busN.LinkAddr       = bus.LinkAddr;
  assign busN.ResultSel      = bus.ResultSel;
  assign busN.LoadType       = bus.LoadType;
  assign busN.ByteOffset     = bus.ByteOffset;
  assign busN.RegWriteIn     = bus.RegWriteIn;
  assign busN.WriteRegAddrIn = bus.WriteRegAddrIn;
  assign busN.DataOut        = bus.DataOut;
  assign busN.DataValid      = bus.DataValid;

  wb_stage_pipelined #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32), .BIG_ENDIAN(0))
    dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  wb_stage_pipelined #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4), .BIG_ENDIAN(0))
    dutN (.Clk(Clk), .Reset(Reset), .bus(busN));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check({tag, ".we"},    32'(bus.RegWriteOut), 32'd1);
    check({tag, ".addr"},  32'(bus.WriteRegAddrOut), 32'(addr));
    check({tag, ".data"},  bus.WriteRegData, data);
    check({tag, ".fwdv"},  32'(bus.FwdValid), 32'd1);
    check({tag, ".fwda"},  32'(bus.FwdAddr), 32'(addr));
    check({tag, ".fwdd"},  bus.FwdData, data);
    check({tag, ".retire"}, bus.RetireCount, 32'(expRetire));
  endtask

  initial begin
    Reset              = 1'b1;
    bus.InValid        = 1'b0;
    bus.Flush          = 1'b0;
    bus.ALUOut         = '0;
    bus.LinkAddr       = '0;
    bus.ResultSel      = 2'b00;
    bus.LoadType       = 3'b000;
    bus.ByteOffset     = 2'b00;
    bus.RegWriteIn     = 1'b0;
    bus.WriteRegAddrIn = '0;
    bus.DataOut        = '0;
    bus.DataValid      = 1'b0;

    // Reset state
    tick(); tick();
    check("rst.we",     32'(bus.RegWriteOut), 32'd0);
    check("rst.addr",   32'(bus.WriteRegAddrOut), 32'd0);
    check("rst.data",   bus.WriteRegData, 32'd0);
    check("rst.fwdv",   32'(bus.FwdValid), 32'd0);
    check("rst.retire", bus.RetireCount, 32'd0);
    check("rst.ready",  32'(bus.InReady), 32'd1);
    Reset = 1'b0;

    // ALU op, latency 1, then write pulse drops
    bus.InValid = 1'b1; bus.ALUOut = 32'h12345678; bus.RegWriteIn = 1'b1;
    bus.WriteRegAddrIn = 5'd5; bus.ResultSel = 2'b00;
    tick(); expRetire++;
    checkWrite("alu", 5'd5, 32'h12345678);
    bus.InValid = 1'b0;
    tick();
    check("alu.pulse_end", 32'(bus.RegWriteOut), 32'd0);
    check("alu.data_hold", bus.WriteRegData, 32'h12345678);

    // Back-to-back ALU ops
    bus.InValid = 1'b1; bus.ALUOut = 32'hA5A5_0001; bus.WriteRegAddrIn = 5'd6;
    tick(); expRetire++;
    checkWrite("b2b0", 5'd6, 32'hA5A5_0001);
    bus.ALUOut = 32'h5A5A_0002; bus.WriteRegAddrIn = 5'd7;
    tick(); expRetire++;
    checkWrite("b2b1", 5'd7, 32'h5A5A_0002);

    // Sub-word loads with data already valid
    bus.ResultSel = 2'b01; bus.DataValid = 1'b1; bus.DataOut = 32'h0080FF00;
    bus.WriteRegAddrIn = 5'd8;
    bus.LoadType = 3'b011; bus.ByteOffset = 2'd2;
    tick(); expRetire++;
    checkWrite("lb2", 5'd8, 32'hFFFFFF80);
    bus.LoadType = 3'b100;
    tick(); expRetire++;
    checkWrite("lbu2", 5'd8, 32'h00000080);
    bus.LoadType = 3'b001;
    tick(); expRetire++;
    checkWrite("lh2", 5'd8, 32'h00000080);
    bus.LoadType = 3'b010; bus.ByteOffset = 2'd0;
    tick(); expRetire++;
    checkWrite("lhu0", 5'd8, 32'h0000FF00);
    bus.LoadType = 3'b011; bus.ByteOffset = 2'd1;
    tick(); expRetire++;
    checkWrite("lb1", 5'd8, 32'hFFFFFFFF);
    bus.LoadType = 3'b001; bus.ByteOffset = 2'd3;
    tick(); expRetire++;
    checkWrite("lh3", 5'd8, 32'h00000080);

    // LW waiting 3 cycles for data; captured fields must survive input changes
    bus.LoadType = 3'b000; bus.ByteOffset = 2'd0; bus.DataValid = 1'b0;
    bus.WriteRegAddrIn = 5'd9;
    tick();
    check("lw.wait0.ready", 32'(bus.InReady), 32'd0);
    check("lw.wait0.we",    32'(bus.RegWriteOut), 32'd0);
    bus.InValid = 1'b0; bus.LoadType = 3'b011; bus.WriteRegAddrIn = 5'd3;
    tick();
    check("lw.wait1.ready", 32'(bus.InReady), 32'd0);
    check("lw.wait1.we",    32'(bus.RegWriteOut), 32'd0);
    tick();
    check("lw.wait2.ready", 32'(bus.InReady), 32'd0);
    check("lw.wait2.we",    32'(bus.RegWriteOut), 32'd0);
    bus.DataValid = 1'b1; bus.DataOut = 32'hDEADBEEF;
    tick(); expRetire++;
    checkWrite("lw.done", 5'd9, 32'hDEADBEEF);
    check("lw.ready", 32'(bus.InReady), 32'd1);
    bus.DataValid = 1'b0; bus.LoadType = 3'b000;

    // Flush beats DataValid in WAIT_MEM
    bus.InValid = 1'b1; bus.WriteRegAddrIn = 5'd10;
    tick();
    bus.InValid = 1'b0; bus.Flush = 1'b1; bus.DataValid = 1'b1; bus.DataOut = 32'h11111111;
    tick();
    check("flush.we",     32'(bus.RegWriteOut), 32'd0);
    check("flush.retire", bus.RetireCount, 32'(expRetire));
    check("flush.ready",  32'(bus.InReady), 32'd1);
    check("flush.data",   bus.WriteRegData, 32'hDEADBEEF);
    bus.DataValid = 1'b0;

    // InValid with Flush in IDLE: nothing captured
    bus.InValid = 1'b1; bus.ResultSel = 2'b00; bus.ALUOut = 32'h0BAD0BAD;
    bus.WriteRegAddrIn = 5'd11;
    tick();
    check("flushin.we",     32'(bus.RegWriteOut), 32'd0);
    check("flushin.retire", bus.RetireCount, 32'(expRetire));
    bus.Flush = 1'b0;

    // Write to r0: no strobe, still retires
    bus.WriteRegAddrIn = 5'd0;
    tick(); expRetire++;
    check("r0.we",     32'(bus.RegWriteOut), 32'd0);
    check("r0.retire", bus.RetireCount, 32'(expRetire));

    // JAL link result
    bus.ResultSel = 2'b10; bus.LinkAddr = 32'h00400008; bus.WriteRegAddrIn = 5'd31;
    tick(); expRetire++;
    checkWrite("jal", 5'd31, 32'h00400008);

    // ResultSel 11 behaves as ALU
    bus.ResultSel = 2'b11; bus.ALUOut = 32'hCAFEF00D; bus.WriteRegAddrIn = 5'd12;
    tick(); expRetire++;
    checkWrite("sel11", 5'd12, 32'hCAFEF00D);

    // Non-writing instruction still retires
    bus.RegWriteIn = 1'b0; bus.ResultSel = 2'b00; bus.WriteRegAddrIn = 5'd13;
    tick(); expRetire++;
    check("nowr.we",     32'(bus.RegWriteOut), 32'd0);
    check("nowr.retire", bus.RetireCount, 32'(expRetire));
    bus.RegWriteIn = 1'b1;

    // Reset during WAIT_MEM, then stale DataValid must not write
    bus.ResultSel = 2'b01; bus.DataValid = 1'b0; bus.WriteRegAddrIn = 5'd14;
    tick();
    check("rstwait.ready0", 32'(bus.InReady), 32'd0);
    bus.InValid = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0; expRetire = 0;
    check("rstwait.we",      32'(bus.RegWriteOut), 32'd0);
    check("rstwait.addr",    32'(bus.WriteRegAddrOut), 32'd0);
    check("rstwait.data",    bus.WriteRegData, 32'd0);
    check("rstwait.fwdd",    bus.FwdData, 32'd0);
    check("rstwait.retire",  bus.RetireCount, 32'd0);
    check("rstwait.retireN", 32'(busN.RetireCount), 32'd0);
    check("rstwait.ready",   32'(bus.InReady), 32'd1);
    bus.DataValid = 1'b1; bus.DataOut = 32'h00000055;
    tick();
    check("stale.we",     32'(bus.RegWriteOut), 32'd0);
    check("stale.retire", bus.RetireCount, 32'd0);
    bus.DataValid = 1'b0;

    // 17 retirements: 4-bit counter wraps to 1
    bus.ResultSel = 2'b00; bus.WriteRegAddrIn = 5'd1; bus.InValid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.ALUOut = 32'(i);
      tick(); expRetire++;
    end
    bus.InValid = 1'b0;
    tick();
    check("wrap.retire",  bus.RetireCount, 32'd17);
    check("wrap.retireN", 32'(busN.RetireCount), 32'd1);
    check("wrap.data",    bus.WriteRegData, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
